// File: rtl/mmio_pwm_pkg.sv
// Shared constants for the memory-mapped PWM peripheral: register offsets,
// the store-word funct3 code and CTRL/STATUS bit positions.
package mmio_pwm_pkg;

    localparam logic [2:0] FUNCT3_SW = 3'b010;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_DUTY_R   = 5'h04;
    localparam logic [4:0] OFF_DUTY_G   = 5'h08;
    localparam logic [4:0] OFF_DUTY_B   = 5'h0C;
    localparam logic [4:0] OFF_DUTY_LED = 5'h10;
    localparam logic [4:0] OFF_STATUS   = 5'h14;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_PRESCALE_LSB  = 8;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_CNT_LSB     = 8;

    localparam int NUM_CH = 4;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair with wrap-time load (or +/-1 fade
// when MMIO_PWM_FADE_EN is defined) and a registered compare output.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                write_en,
    input  logic [PWM_BITS-1:0] write_duty,
    output logic [PWM_BITS-1:0] shadow,
    output logic                settled,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] active;
    logic [PWM_BITS-1:0] active_next;

    // Active always loads the pre-write shadow, so a write landing in the wrap
    // cycle only takes effect on the following wrap.
    always_comb begin
        active_next = active;
        if (!enable) begin
            active_next = shadow;
        end else if (wrap) begin
`ifdef MMIO_PWM_FADE_EN
            if (active < shadow) begin
                active_next = active + 1'b1;
            end else if (active > shadow) begin
                active_next = active - 1'b1;
            end
`else
            active_next = shadow;
`endif
        end
    end

    assign settled = (active_next == shadow);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            active  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (write_en) begin
                shadow <= write_duty;
            end
            active  <= active_next;
            pwm_out <= enable && (cnt < active);
        end
    end

endmodule

// File: rtl/mmio_pwm.sv
// Memory-mapped 4-channel PWM (RGB + LED) with double-buffered duties and
// registered lw readback. Define MMIO_PWM_FADE_EN for +/-1 per-period fading.
module mmio_pwm
    import mmio_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'hFFFF_FFE0,
    parameter int          PWM_BITS      = 8,
    parameter int          PRESCALE_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        red,
    output logic        green,
    output logic        blue,
    output logic        led
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic                     enable;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PRESCALE_BITS-1:0] pcnt;
    logic [PWM_BITS-1:0]      cnt;
    logic                     pending;
    logic                     tick;
    logic                     wrap;

    logic                     accept;
    logic                     ctrl_wr;
    logic                     duty_wr;
    logic [4:0]               wr_off;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH-1:0]        ch_settled;
    logic [NUM_CH-1:0]        ch_out;
    logic [PWM_BITS-1:0]      shadow [NUM_CH];

    logic                     rd_in_window;
    logic [31:0]              rd_mux;
    logic                     unused_bits;

    assign wr_off  = write_address[4:0];
    assign accept  = write_mem && (funct3 == FUNCT3_SW)
                     && (write_address[31:5] == BASE_ADDR[31:5])
                     && (write_address[1:0] == 2'b00);
    assign ctrl_wr = accept && (wr_off == OFF_CTRL);
    assign duty_wr = |ch_we;

    assign tick = enable && (pcnt == prescale);
    assign wrap = tick && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable   <= 1'b0;
            prescale <= '0;
        end else if (ctrl_wr) begin
            enable   <= write_data[CTRL_EN_BIT];
            prescale <= write_data[CTRL_PRESCALE_LSB +: PRESCALE_BITS];
        end
    end

    // Both counters park at 0 while disabled so re-enabling starts a fresh period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (!enable) begin
            pcnt <= '0;
            cnt  <= '0;
        end else begin
            if (ctrl_wr || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (!enable) begin
            pending <= 1'b0;
        end else if (duty_wr) begin
            pending <= 1'b1;
        end else if (wrap) begin
`ifdef MMIO_PWM_FADE_EN
            pending <= ~&ch_settled;
`else
            pending <= 1'b0;
`endif
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [4:0] CH_OFF = OFF_DUTY_R + 5'(4 * i);

        assign ch_we[i] = accept && (wr_off == CH_OFF);

        pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .wrap      (wrap),
            .cnt       (cnt),
            .write_en  (ch_we[i]),
            .write_duty(write_data[PWM_BITS-1:0]),
            .shadow    (shadow[i]),
            .settled   (ch_settled[i]),
            .pwm_out   (ch_out[i])
        );
    end

    assign red   = ch_out[0];
    assign green = ch_out[1];
    assign blue  = ch_out[2];
    assign led   = ch_out[3];

    // Readback handshake: read_hit is the valid for read_data, presented one
    // cycle after read_address; there is no ready, every address is sampled.
    assign rd_in_window = (read_address[31:5] == BASE_ADDR[31:5]);

    always_comb begin
        rd_mux = '0;
        case (read_address[4:2])
            OFF_CTRL[4:2]: begin
                rd_mux[CTRL_EN_BIT]                         = enable;
                rd_mux[CTRL_PRESCALE_LSB +: PRESCALE_BITS]  = prescale;
            end
            OFF_DUTY_R[4:2]:   rd_mux[PWM_BITS-1:0] = shadow[0];
            OFF_DUTY_G[4:2]:   rd_mux[PWM_BITS-1:0] = shadow[1];
            OFF_DUTY_B[4:2]:   rd_mux[PWM_BITS-1:0] = shadow[2];
            OFF_DUTY_LED[4:2]: rd_mux[PWM_BITS-1:0] = shadow[3];
            OFF_STATUS[4:2]: begin
                rd_mux[STATUS_PENDING_BIT]               = pending && enable;
                rd_mux[STATUS_CNT_LSB +: PWM_BITS]       = cnt;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
            read_hit  <= 1'b0;
        end else begin
            read_data <= rd_in_window ? rd_mux : 32'h0;
            read_hit  <= rd_in_window;
        end
    end

`ifdef MMIO_PWM_FADE_EN
    assign unused_bits = ^{write_data, read_address[1:0]};
`else
    assign unused_bits = ^{write_data, read_address[1:0], ch_settled};
`endif

endmodule

// File: tb/tb_mmio_pwm.sv
// Bench for mmio_pwm: directed scenarios plus random bus traffic, checked
// cycle by cycle against a behavioural model through an expected-value queue.
module tb_mmio_pwm;

    localparam logic [31:0] BASE = 32'hFFFF_FFE0;
    localparam int          PMAX = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_mem = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] write_address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_address = 32'h0;
    logic [31:0] read_data;
    logic        read_hit;
    logic        red, green, blue, led;

    mmio_pwm dut (
        .clk          (clk),
        .reset        (reset),
        .write_mem    (write_mem),
        .funct3       (funct3),
        .write_address(write_address),
        .write_data   (write_data),
        .read_address (read_address),
        .read_data    (read_data),
        .read_hit     (read_hit),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .led          (led)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  pin_q[$];
    logic [32:0] exp_q[$];

    // ---------------- reference model ----------------
    bit m_en;
    int m_pre, m_pcnt, m_cnt;
    int m_sh[4];
    int m_act[4];
    bit m_pend;
    logic [3:0] m_pins;

    task automatic model_reset();
        m_en = 0; m_pre = 0; m_pcnt = 0; m_cnt = 0; m_pend = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 0;
            m_act[i] = 0;
        end
    endtask

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] r;
        int w;
        r = 32'h0;
        w = int'(a[4:2]);
        if (a[31:5] == BASE[31:5]) begin
            if (w == 0) r = {16'h0, 8'(m_pre), 7'h0, m_en};
            else if (w >= 1 && w <= 4) r = 32'(m_sh[w-1]);
            else if (w == 5) r = {16'h0, 8'(m_cnt), 7'h0, (m_pend && m_en)};
        end
        return r;
    endfunction

    // Advance the model by one clock using the bus inputs present at the edge.
    task automatic model_step();
        bit acc, tick, wrap, dw, cw;
        int off;
        int nact[4];
        acc  = write_mem && funct3 == 3'b010 && write_address[31:5] == BASE[31:5]
               && write_address[1:0] == 2'b00;
        off  = int'(write_address[4:0]);
        cw   = acc && off == 0;
        dw   = acc && off >= 4 && off <= 16;
        tick = m_en && (m_pcnt == m_pre);
        wrap = tick && (m_cnt == PMAX);
        for (int i = 0; i < 4; i++) begin
            if (!m_en) nact[i] = m_sh[i];
            else if (wrap) begin
`ifdef MMIO_PWM_FADE_EN
                nact[i] = m_act[i] + ((m_sh[i] > m_act[i]) ? 1 : 0) - ((m_sh[i] < m_act[i]) ? 1 : 0);
`else
                nact[i] = m_sh[i];
`endif
            end else nact[i] = m_act[i];
        end
        if (!m_en) m_pend = 0;
        else if (dw) m_pend = 1;
        else if (wrap) begin
            m_pend = 0;
`ifdef MMIO_PWM_FADE_EN
            for (int i = 0; i < 4; i++) if (nact[i] != m_sh[i]) m_pend = 1;
`endif
        end
        if (!m_en || cw || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (!m_en) m_cnt = 0;
        else if (tick) m_cnt = (m_cnt + 1) % (PMAX + 1);
        for (int i = 0; i < 4; i++) m_act[i] = nact[i];
        if (dw) m_sh[off/4 - 1] = int'(write_data[7:0]);
        if (cw) begin
            m_en  = write_data[0];
            m_pre = int'(write_data[15:8]);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            pin_q.push_back(4'h0);
            exp_q.push_back(33'h0);
        end else begin
            for (int i = 0; i < 4; i++) m_pins[i] = m_en && (m_cnt < m_act[i]);
            pin_q.push_back(m_pins);
            exp_q.push_back({read_address[31:5] == BASE[31:5], model_read(read_address)});
            model_step();
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [3:0]  exp_pins;
    logic [32:0] exp_rd;

    always @(negedge clk) begin
        if (pin_q.size() > 0) begin
            exp_pins = pin_q.pop_front();
            n_tests++;
            if ({led, blue, green, red} !== exp_pins) begin
                n_fail++;
                $display("FAIL pins @%0t: got %b expected %b (led,blue,green,red)",
                         $time, {led, blue, green, red}, exp_pins);
            end
        end
        if (exp_q.size() > 0) begin
            exp_rd = exp_q.pop_front();
            n_tests++;
            if ({read_hit, read_data} !== exp_rd) begin
                n_fail++;
                $display("FAIL readback @%0t: got hit=%b data=%h expected hit=%b data=%h",
                         $time, read_hit, read_data, exp_rd[32], exp_rd[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(logic [31:0] addr, logic [31:0] data, logic [2:0] f3 = 3'b010);
        write_mem     = 1'b1;
        funct3        = f3;
        write_address = addr;
        write_data    = data;
        cyc(1);
        write_mem     = 1'b0;
        funct3        = 3'b000;
    endtask

    task automatic check(string name, logic [32:0] got, logic [32:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Asserts reset away from the clock edge, mid-period.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        pin_q.delete();
        exp_q.delete();
        #1;
        check("reset_pins", 33'({led, blue, green, red}), 33'h0);
        check("reset_read_data", 33'(read_data), 33'h0);
        check("reset_read_hit", 33'(read_hit), 33'h0);
        cyc(3);
        reset = 1'b1;
    endtask

    task automatic wait_wrap_next();
        int guard = 0;
        while (!(m_en && m_pcnt == m_pre && m_cnt == PMAX) && guard < 5000) begin
            cyc(1);
            guard++;
        end
        check("wrap_wait_timeout", 33'(guard >= 5000), 33'h0);
    endtask

    task automatic wait_cnt(int v);
        int guard = 0;
        while (m_cnt != v && guard < 5000) begin
            cyc(1);
            guard++;
        end
        check("cnt_wait_timeout", 33'(guard >= 5000), 33'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1 reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        read_address = BASE + 32'h14;
        cyc(2);

        // basic PWM: duty written while disabled, then enable with prescale 0
        bus_wr(BASE + 32'h04, 32'd64);
        bus_wr(BASE + 32'h00, 32'h0000_0001);
        cyc(520);

        // double buffering on green
        bus_wr(BASE + 32'h08, 32'd200);
        wait_wrap_next();
        cyc(1);
        wait_cnt(50);
        bus_wr(BASE + 32'h08, 32'd10);
        cyc(600);

        // filtered writes and an out-of-window read
        bus_wr(BASE + 32'h04, 32'd99, 3'b000);
        bus_wr(BASE + 32'h02, 32'd99);
        bus_wr(BASE + 32'h20, 32'd99);
        read_address = BASE + 32'h20;
        cyc(2);
        read_address = BASE + 32'h04;
        cyc(2);
        read_address = BASE + 32'h14;

        // prescale 3, then a CTRL rewrite mid-count
        bus_wr(BASE + 32'h00, 32'h0000_0301);
        cyc(2100);
        cyc($urandom_range(1, 3));
        bus_wr(BASE + 32'h00, 32'h0000_0301);
        cyc(40);

        // duty write landing exactly on the wrap edge
        bus_wr(BASE + 32'h00, 32'h0000_0001);
        bus_wr(BASE + 32'h0C, 32'd20);
        wait_wrap_next();
        cyc(1);
        wait_wrap_next();
`ifdef MMIO_PWM_FADE_EN
        bus_wr(BASE + 32'h0C, 32'd23);
        cyc(1100);
`else
        bus_wr(BASE + 32'h0C, 32'd30);
        cyc(600);
`endif

        // reset mid-period with red running at 128
        bus_wr(BASE + 32'h04, 32'd128);
        cyc(300);
        apply_reset();
        cyc(300);

        // random bus traffic
        for (int k = 0; k < 3000; k++) begin
            int op;
            op = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0)
                read_address = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            else
                read_address = $urandom();
            if (op == 0) begin
                bus_wr(BASE, {$urandom_range(0, 65535), 8'($urandom_range(0, 1)), 7'($urandom()),
                              ($urandom_range(0, 3) != 0)});
            end else if (op <= 2) begin
                bus_wr(BASE + {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom());
            end else if (op == 3) begin
                bus_wr(BASE + 32'($urandom_range(0, 31)), $urandom(), 3'($urandom_range(0, 7)));
            end else begin
                cyc(1);
            end
        end

        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
